// File: rtl/block_renderer_pkg.sv
// Shared constants, game status encodings and FSM state type for the block renderer.
// The FILL state exists only when RENDER_GAMEOVER_FILL_EN is defined.
package render_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] FILL_OVER_COLOUR = 3'b100;
    localparam logic [2:0] FILL_WIN_COLOUR  = 3'b010;

    typedef enum logic [1:0] {
        GS_START = 2'b00,
        GS_PLAY  = 2'b01,
        GS_OVER  = 2'b10,
        GS_WIN   = 2'b11
    } game_status_e;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ERASE,
        ST_DRAW
`ifdef RENDER_GAMEOVER_FILL_EN
        , ST_FILL
`endif
    } render_state_e;

    // Sums arrive one bit wider than the screen coordinates, so a wrapped
    // column such as 250+10 stays at 260 and is rejected instead of aliasing to 4.
    function automatic logic onScreen(input logic [8:0] col, input logic [7:0] row);
        return (col < 9'(SCREEN_W)) && (row < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/block_renderer_if.sv
// Request/pixel bus between the game logic (master) and the block renderer (slave).
interface block_renderer_if;

    logic       sync;
    logic [7:0] x;
    logic [7:0] prev_x;
    logic [6:0] y;
    logic [1:0] game_status;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output sync, x, prev_x, y, game_status,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  sync, x, prev_x, y, game_status,
        output vga_x, vga_y, colour, plot, busy, done
    );

endinterface

// File: rtl/block_renderer_rect_scanner.sv
// Row-major (dx, dy) offset generator for a rectangle whose size is given at run time,
// shared by every renderer pass (clear, erase, draw and the optional fill).
module rect_scanner (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_i,
    input  logic [7:0] wLast_i,
    input  logic [6:0] hLast_i,
    output logic       valid_o,
    output logic       last_o,
    output logic [7:0] dx_o,
    output logic [6:0] dy_o
);

    logic       active_q;
    logic [7:0] dx_q;
    logic [6:0] dy_q;

    // Reset arms the scanner at the origin because the renderer always clears the screen first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b1;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (active_q) begin
            if (dx_q == wLast_i) begin
                dx_q <= '0;
                if (dy_q == hLast_i) begin
                    active_q <= 1'b0;
                    dy_q     <= '0;
                end else begin
                    dy_q <= dy_q + 7'd1;
                end
            end else begin
                dx_q <= dx_q + 8'd1;
            end
        end
    end

    assign valid_o = active_q;
    assign last_o  = active_q && (dx_q == wLast_i) && (dy_q == hLast_i);
    assign dx_o    = dx_q;
    assign dy_o    = dy_q;

endmodule

// File: rtl/block_renderer.sv
// Block renderer: clears the screen after reset, then erases/redraws a block per sync tick.
// Optional macro RENDER_GAMEOVER_FILL_EN adds a full-screen red/green FILL for OVER/WIN.
module block_renderer
    import render_pkg::*;
#(
    parameter int unsigned BLOCK_W      = 16,
    parameter int unsigned BLOCK_H      = 4,
    parameter logic [2:0]  BLOCK_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
    input logic             clk,
    input logic             resetn,
    block_renderer_if.slave bus
);

    render_state_e state_q;
    logic          pending_q;
    logic [7:0]    x_q;
    logic [7:0]    prevX_q;
    logic [6:0]    y_q;
    logic          plot_q;
    logic          done_q;
    logic          busy_q;
    logic [7:0]    vgaX_q;
    logic [6:0]    vgaY_q;
    logic [2:0]    colour_q;
`ifdef RENDER_GAMEOVER_FILL_EN
    logic [2:0]    fillColour_q;
`endif

    logic       scanStart;
    logic       scanValid;
    logic       scanLast;
    logic [7:0] scanDx;
    logic [6:0] scanDy;
    logic [7:0] wLast;
    logic [6:0] hLast;
    logic       fullScreen;
    logic [7:0] originX;
    logic [6:0] originY;
    logic [8:0] colSum;
    logic [7:0] rowSum;
    logic [2:0] pixColour;

    rect_scanner u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (scanStart),
        .wLast_i (wLast),
        .hLast_i (hLast),
        .valid_o (scanValid),
        .last_o  (scanLast),
        .dx_o    (scanDx),
        .dy_o    (scanDy)
    );

    // Pixel address and colour for whichever pass is running; erase restarts into draw seamlessly.
    always_comb begin
        fullScreen = (state_q == ST_CLEAR);
`ifdef RENDER_GAMEOVER_FILL_EN
        fullScreen = fullScreen || (state_q == ST_FILL);
`endif
        originX = (state_q == ST_ERASE) ? prevX_q : x_q;
        originY = y_q;
        if (fullScreen) begin
            originX = '0;
            originY = '0;
        end
        colSum    = {1'b0, originX} + {1'b0, scanDx};
        rowSum    = {1'b0, originY} + {1'b0, scanDy};
        pixColour = (state_q == ST_DRAW) ? BLOCK_COLOUR : BG_COLOUR;
`ifdef RENDER_GAMEOVER_FILL_EN
        if (state_q == ST_FILL) pixColour = fillColour_q;
`endif
        wLast     = fullScreen ? 8'(SCREEN_W - 1) : 8'(BLOCK_W - 1);
        hLast     = fullScreen ? 7'(SCREEN_H - 1) : 7'(BLOCK_H - 1);
        scanStart = ((state_q == ST_IDLE) && (bus.sync || pending_q))
                 || ((state_q == ST_ERASE) && scanLast);
    end

    // A pass ends the cycle after its last pixel, which is where done pulses and the FSM idles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_CLEAR;
            pending_q <= 1'b0;
            x_q       <= '0;
            prevX_q   <= '0;
            y_q       <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            vgaX_q    <= '0;
            vgaY_q    <= '0;
            colour_q  <= BG_COLOUR;
`ifdef RENDER_GAMEOVER_FILL_EN
            fillColour_q <= FILL_OVER_COLOUR;
`endif
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.sync && (state_q != ST_IDLE)) pending_q <= 1'b1;

            if (scanValid && (state_q != ST_IDLE)) begin
                plot_q <= onScreen(colSum, rowSum);
                if (onScreen(colSum, rowSum)) begin
                    vgaX_q   <= colSum[7:0];
                    vgaY_q   <= rowSum[6:0];
                    colour_q <= pixColour;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.sync || pending_q) begin
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        x_q       <= bus.x;
                        prevX_q   <= bus.prev_x;
                        y_q       <= bus.y;
                        state_q   <= ST_ERASE;
`ifdef RENDER_GAMEOVER_FILL_EN
                        if (bus.game_status == GS_OVER) begin
                            fillColour_q <= FILL_OVER_COLOUR;
                            state_q      <= ST_FILL;
                        end else if (bus.game_status == GS_WIN) begin
                            fillColour_q <= FILL_WIN_COLOUR;
                            state_q      <= ST_FILL;
                        end
`endif
                    end
                end
                ST_ERASE: begin
                    if (scanLast) state_q <= ST_DRAW;
                end
                default: begin
                    if (!scanValid) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.plot   = plot_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.vga_x  = vgaX_q;
    assign bus.vga_y  = vgaY_q;
    assign bus.colour = colour_q;

endmodule

// File: tb/tb_block_renderer.sv
// Self-checking bench for block_renderer: plots are collected and compared against a
// queue of expected pixels built from the screen/block geometry rules.
module tb_block_renderer;

    localparam int         BW  = 16;
    localparam int         BH  = 4;
    localparam logic [2:0] BLK = 3'b111;
    localparam logic [2:0] BG  = 3'b000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    block_renderer_if bus();

    block_renderer #(
        .BLOCK_W      (BW),
        .BLOCK_H      (BH),
        .BLOCK_COLOUR (BLK),
        .BG_COLOUR    (BG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] expQ[$];
    logic [17:0] obsQ[$];
    logic [17:0] lastVis;
    int          expCycles;
    int          startCyc, firstPlot, doneAt, doneCount;
    bit          timedOut;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic addRect(input int x0, input int y0, input int w, input int h, input logic [2:0] c);
        for (int r = 0; r < h; r++)
            for (int col = 0; col < w; col++)
                if ((x0 + col) < 160 && (y0 + r) < 120)
                    expQ.push_back({8'(x0 + col), 7'(y0 + r), c});
    endtask

    task automatic buildClear();
        expQ.delete();
        addRect(0, 0, 160, 120, BG);
        expCycles = 19200;
    endtask

    task automatic buildOp(input int x, input int px, input int y, input logic [1:0] gs);
        expQ.delete();
        expCycles = 2 * BW * BH;
`ifdef RENDER_GAMEOVER_FILL_EN
        if (gs == 2'b10 || gs == 2'b11) begin
            addRect(0, 0, 160, 120, (gs == 2'b10) ? 3'b100 : 3'b010);
            expCycles = 19200;
            return;
        end
`endif
        addRect(px, y, BW, BH, BG);
        addRect(x, y, BW, BH, BLK);
    endtask

    task automatic applyStimulus(input int x, input int px, input int y, input logic [1:0] gs, input bit pulse);
        @(negedge clk);
        bus.x           = 8'(x);
        bus.prev_x      = 8'(px);
        bus.y           = 7'(y);
        bus.game_status = gs;
        bus.sync        = pulse;
    endtask

    // Collects plots until done; negedge n drives sync seen at the n-th edge after the request edge.
    task automatic captureOp(input int s1, input int s2, input int s3, input int budget);
        int n;
        obsQ.delete();
        doneCount = 0;
        firstPlot = -1;
        doneAt    = -1;
        n         = 0;
        while (doneCount == 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1) startCyc = cyc;
            if (bus.plot === 1'b1) begin
                if (firstPlot < 0) firstPlot = cyc;
                obsQ.push_back({bus.vga_x, bus.vga_y, bus.colour});
            end
            if (bus.done === 1'b1) begin
                doneCount++;
                doneAt = cyc;
            end
            bus.sync = (n == s1 || n == s2 || n == s3);
        end
        bus.sync = 1'b0;
        timedOut = (doneCount == 0);
    endtask

    function automatic int firstDiff();
        int n;
        n = (obsQ.size() > expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obsQ.size() || i >= expQ.size()) return i;
            if (obsQ[i] !== expQ[i]) return i;
        end
        return -1;
    endfunction

    task automatic verifyOp(input string tag, input int expLatency);
        int d;
        checkOutput({tag, "_timeout"}, 32'(timedOut), 0);
        checkOutput({tag, "_plots"}, obsQ.size(), expQ.size());
        d = firstDiff();
        if (d >= 0 && d < obsQ.size() && d < expQ.size())
            $display("[TB] %s pixel %0d: observed %05h expected %05h", tag, d, obsQ[d], expQ[d]);
        checkOutput({tag, "_diffidx"}, d, -1);
        checkOutput({tag, "_latency"}, doneAt - startCyc, expLatency);
        if (expQ.size() > 0) lastVis = expQ[$];
    endtask

    task automatic afterOp(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, bus.done, 0);
        checkOutput({tag, "_busy_low"}, bus.busy, 0);
        checkOutput({tag, "_idle_plot"}, bus.plot, 0);
        checkOutput({tag, "_hold_pix"}, {bus.vga_x, bus.vga_y, bus.colour}, lastVis);
    endtask

    task automatic idleWindow(input string tag, input int len);
        int cnt;
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0) cnt++;
        end
        checkOutput({tag, "_quiet"}, cnt, 0);
    endtask

    task automatic runOp(input string tag, input int x, input int px, input int y, input logic [1:0] gs);
        buildOp(x, px, y, gs);
        applyStimulus(x, px, y, gs, 1'b1);
        captureOp(-1, -1, -1, expCycles + 100);
        verifyOp(tag, expCycles + 1);
        afterOp(tag);
    endtask

    initial begin
        int rx, rpx, ry, doneFirst;
        logic [1:0] rgs;
        bus.sync = 1'b0; bus.x = '0; bus.prev_x = '0; bus.y = '0; bus.game_status = 2'b01;
        lastVis = '0;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_plot", bus.plot, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_vga", {bus.vga_x, bus.vga_y}, 0);
        checkOutput("rst_colour", bus.colour, BG);
        checkOutput("rst_busy", bus.busy, 1);

        // Clear after release: first pixel on the first edge with resetn high
        buildClear();
        resetn = 1'b1;
        captureOp(-1, -1, -1, 19400);
        checkOutput("clear_first", firstPlot - startCyc, 0);
        verifyOp("clear", 19200);
        afterOp("clear");

        // Directed erase/draw
        buildOp(24, 20, 50, 2'b01);
        applyStimulus(24, 20, 50, 2'b01, 1'b1);
        captureOp(-1, -1, -1, 300);
        checkOutput("basic_first", firstPlot - startCyc, 1);
        checkOutput("basic_done", doneAt - firstPlot, 128);
        verifyOp("basic", 129);
        afterOp("basic");

        // Right/bottom clipping and wrapped columns
        runOp("clip_x", 150, 100, 30, 2'b01);
        runOp("clip_y", 40, 10, 118, 2'b00);
        runOp("wrap_x", 250, 60, 10, 2'b01);
        runOp("overlap", 70, 64, 80, 2'b00);

        for (int k = 0; k < 4; k++) begin
            rx  = $urandom_range(0, 255);
            rpx = $urandom_range(0, 255);
            ry  = $urandom_range(0, 127);
            rgs = 2'($urandom_range(0, 1));
            runOp($sformatf("rand%0d", k), rx, rpx, ry, rgs);
        end

        // Three syncs while busy collapse into one follow-up using inputs present at done
        buildOp(30, 30, 20, 2'b01);
        applyStimulus(30, 30, 20, 2'b01, 1'b1);
        captureOp(10, 20, 30, 300);
        verifyOp("multi1", 129);
        doneFirst = doneAt;
        rx = $urandom_range(0, 140); rpx = $urandom_range(0, 140); ry = $urandom_range(0, 100);
        bus.x = 8'(rx); bus.prev_x = 8'(rpx); bus.y = 7'(ry);
        buildOp(rx, rpx, ry, 2'b01);
        captureOp(-1, -1, -1, 300);
        checkOutput("multi2_start", firstPlot - doneFirst, 2);
        verifyOp("multi2", 129);
        afterOp("multi2");
        idleWindow("multi", 40);

        // Sync on the done edge becomes pending
        buildOp(5, 90, 60, 2'b01);
        applyStimulus(5, 90, 60, 2'b01, 1'b1);
        captureOp(129, -1, -1, 300);
        verifyOp("donesync1", 129);
        doneFirst = doneAt;
        buildOp(5, 90, 60, 2'b01);
        captureOp(-1, -1, -1, 300);
        checkOutput("donesync2_start", firstPlot - doneFirst, 2);
        verifyOp("donesync2", 129);
        afterOp("donesync2");

        // Game-over request: fill with the macro, ordinary erase/draw without it
        runOp("gameover", 12, 8, 40, 2'b10);

        // Reset during DRAW aborts, drops the pending request and restarts the clear
        applyStimulus(44, 40, 70, 2'b01, 1'b1);
        for (int n = 1; n < 90; n++) begin
            @(negedge clk);
            bus.sync = (n == 5);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_plot", bus.plot, 0);
        checkOutput("midrst_busy", bus.busy, 1);
        checkOutput("midrst_vga", {bus.vga_x, bus.vga_y, bus.colour}, {15'd0, BG});
        buildClear();
        resetn = 1'b1;
        captureOp(-1, -1, -1, 19400);
        verifyOp("reclear", 19200);
        afterOp("reclear");
        idleWindow("reclear", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_renderer.md
BLOCK_RENDERER -- requirements
Module: block_renderer

Interface
REQ-001 Parameter BLOCK_W, 16, block width in pixels (1..32).
REQ-002 Parameter BLOCK_H, 4, block height in pixels (1..16).
REQ-003 Parameter BLOCK_COLOUR, 3'b111, colour of drawn block.
REQ-004 Parameter BG_COLOUR, 3'b000, background/erase colour.
REQ-005 clk  input  1  50MHz system clock; all logic on rising edge.
REQ-006 resetn  input  1  reset; synchronous, active-low.
REQ-007 sync  input  1  one-cycle frame tick from game logic; requests a redraw.
REQ-008 x  input  8  current block left-edge column.
REQ-009 prev_x  input  8  previous block left-edge column (to erase).
REQ-010 y  input  7  block top row.
REQ-011 game_status  input  2  00 START, 01 PLAY, 10 OVER, 11 WIN.
REQ-012 vga_x  output  8  pixel column to VGA adapter.
REQ-013 vga_y  output  7  pixel row to VGA adapter.
REQ-014 colour  output  3  pixel colour.
REQ-015 plot  output  1  write-enable for the pixel on vga_x/vga_y/colour.
REQ-016 busy  output  1  high whenever FSM is not IDLE.
REQ-017 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-018 FSM states SHALL be CLEAR, IDLE, ERASE, DRAW, FILL (FILL only with macro).
REQ-019 In IDLE, sync=1 at edge N SHALL snapshot x, prev_x, y, game_status and enter ERASE; first pixel (prev_x, y) SHALL appear with plot=1 after edge N+1.
REQ-020 ERASE SHALL scan BLOCK_W*BLOCK_H pixels, one per cycle, row-major from (prev_x, y), colour=BG_COLOUR; then DRAW scans same size from (x, y) with BLOCK_COLOUR; overlapping pixels end as BLOCK_COLOUR.
REQ-021 Pixels with column >= 160 or row >= 120 SHALL have plot=0 while the scan still consumes the cycle (fixed latency 2*BLOCK_W*BLOCK_H cycles).
REQ-022 Coordinate sums SHALL be computed at 9/8 bits so wrap-around never aliases into visible pixels.
REQ-023 After the last DRAW pixel, FSM SHALL return to IDLE and pulse done for exactly one cycle.
REQ-024 sync arriving while busy SHALL set a one-deep pending flag; further syncs while pending is set are dropped; on return to IDLE with pending set, a new operation SHALL start next cycle using inputs sampled that cycle, and pending clears.
REQ-025 sync coincident with the done cycle SHALL be treated as pending, not lost.
REQ-026 game_status values other than PLAY SHALL not alter ERASE/DRAW behaviour unless the macro is defined.
REQ-027 plot SHALL be 0 in IDLE; vga_x/vga_y/colour hold last values when plot=0.

Reset
REQ-028 resetn=0 SHALL, at the next edge, abort any operation, clear pending, and force plot=0, done=0, vga_x=0, vga_y=0, colour=BG_COLOUR, busy=1.
REQ-029 On release, FSM SHALL run CLEAR: all 160x120 pixels painted BG_COLOUR row-major from (0,0), 19200 cycles, then done pulse and IDLE; syncs during CLEAR set pending.

Configuration
REQ-030 Macro RENDER_GAMEOVER_FILL_EN: when defined, an accepted request with snapshot game_status=OVER SHALL enter FILL, painting all 19200 pixels 3'b100 (red), then done/IDLE; WIN likewise with 3'b010 (green).
REQ-031 Without RENDER_GAMEOVER_FILL_EN, FILL state and its logic SHALL be absent and all requests take ERASE/DRAW.

Structure
REQ-032 Package render_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, game_status encodings, FSM state typedef, fill colours.
REQ-033 One sub-module rect_scanner SHALL generate row-major (dx, dy) offsets for a WxH rectangle with start/last outputs, reused for ERASE, DRAW, CLEAR and FILL.

Verification
REQ-034 Reset then release -> 19200 plots of BG_COLOUR covering (0,0)..(159,119), one done pulse, busy low after.
REQ-035 sync with prev_x=20, x=24, y=50 -> 64 erase plots from (20,50), then 64 draw plots from (24,50), done pulse 128 cycles after first plot.
REQ-036 x=150, BLOCK_W=16 -> columns 160..165 have plot=0; total cycles unchanged.
REQ-037 Three syncs during one operation -> exactly one follow-up operation, started the cycle after done.
REQ-038 resetn low mid-DRAW -> plot=0 next cycle, CLEAR restarts from (0,0), pending cleared.
REQ-039 With RENDER_GAMEOVER_FILL_EN, sync with game_status=10 -> 19200 red plots; without macro -> normal 128-cycle erase/draw.
